ushift_reg: RTL and testbench

- Parametrised universal shift register. It is the successor to the single-bit D storage element, generalised to a WIDTH-bit word.
- Supports hold, parallel load, logical shift left/right, rotate left/right and clear.
- Adds a burst mode: one start command performs a programmed number of shift/rotate steps, with busy/done handshake.
- Used as the shared data-path register for serial/parallel conversion and for the controller exercises.

---
 rtl/ushift_reg.sv | 165 ++++++++++++++++
 tb/tb_ushift_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ushift_reg.sv
// ushift_reg: WIDTH-bit universal shift register with a counted burst mode.
//
// Single-cycle operations (hold, load, SHL, SHR, ROL, ROR, clear) are
// selected by mode. A start request with a shift/rotate mode runs cnt steps
// of that mode automatically, with a busy/done handshake.
//
// Optional build macro: USHIFT_PARITY_EN adds the combinational parity port.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset (highest priority)
//   en      step enable; low holds q and pauses a running burst
//   mode    operation select (000 hold, 001 load, 010 SHL, 011 SHR,
//           100 ROL, 101 ROR, 110 clear, 111 hold)
//   d_in    parallel load data
//   si_l    serial input entering at the MSB on SHR
//   si_r    serial input entering at the LSB on SHL
//   start   burst request, honoured only in IDLE with a shift/rotate mode
//   cnt     burst step count, sampled together with start
//   q       register contents
//   so_l    q[WIDTH-1], combinational
//   so_r    q[0], combinational
//   busy    high while a burst is running
//   done    one-cycle pulse after the last burst step
//   parity  XOR reduction of q (only with USHIFT_PARITY_EN)

module ushift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             si_l,
  input  logic             si_r,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
`ifdef USHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_CLEAR = 3'b110;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One step of operation m applied to value v.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      M_LOAD:  r = ld;
      M_SHL:   r = {v[WIDTH-2:0], sr};
      M_SHR:   r = {sl, v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_CLEAR: r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  logic is_shift_c;
  assign is_shift_c = (mode >= M_SHL) && (mode <= M_ROR);

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_shift_c) begin
          // Start edge only arms the burst; the first step is on the next edge.
          if (cnt != '0) begin
            mode_d  = mode;
            rem_d   = cnt;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else if (en) begin
          q_d = apply_op(mode, q_q, d_in, si_l, si_r);
        end
      end
      ST_RUN: begin
        if (en) begin
          q_d = apply_op(mode_q, q_q, d_in, si_l, si_r);
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end
          // rem_q <= 1 also guards against a stuck burst if rem ever reached 0.
          if (rem_q <= CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // busy/done are flops holding the decode of the next state.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      mode_q  <= M_HOLD;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign so_l = q_q[WIDTH-1];
  assign so_r = q_q[0];
  assign busy = busy_q;
  assign done = done_q;

`ifdef USHIFT_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_ushift_reg.sv
// tb_ushift_reg: directed, self-checking bench for ushift_reg (WIDTH=8, CNT_W=4).
// Single-cycle operations come from a vector table; burst corner cases are
// hand-written sequences.

module tb_ushift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d_in;
  logic             si_l;
  logic             si_r;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             so_l;
  logic             so_r;
  logic             busy;
  logic             done;
`ifdef USHIFT_PARITY_EN
  logic             parity;
`endif

  int checks = 0;
  int errors = 0;

  ushift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .d_in  (d_in),
    .si_l  (si_l),
    .si_r  (si_r),
    .start (start),
    .cnt   (cnt),
    .q     (q),
    .so_l  (so_l),
    .so_r  (so_r),
    .busy  (busy),
    .done  (done)
`ifdef USHIFT_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d_in;
    logic             si_l;
    logic             si_r;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [WIDTH-1:0] eq,
                           input logic eb, input logic ed);
    check({name, ".q"},    32'(q),    32'(eq));
    check({name, ".busy"}, 32'(busy), 32'(eb));
    check({name, ".done"}, 32'(done), 32'(ed));
`ifdef USHIFT_PARITY_EN
    check({name, ".parity"}, 32'(parity), 32'(^eq));
`endif
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;

    // Single-cycle op table, starting from q=00 after reset.
    vecs[0]  = '{1'b1, 1'b0, 3'b001, 8'hA5, 1'b0, 1'b0, 8'hA5}; // load
    vecs[1]  = '{1'b1, 1'b0, 3'b010, 8'h00, 1'b0, 1'b1, 8'h4B}; // SHL si_r=1
    vecs[2]  = '{1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 8'h4B}; // en=0 hold
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h4B}; // mode 000
    vecs[4]  = '{1'b1, 1'b0, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h4B}; // mode 111
    vecs[5]  = '{1'b1, 1'b0, 3'b011, 8'h00, 1'b1, 1'b0, 8'hA5}; // SHR si_l=1
    vecs[6]  = '{1'b1, 1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 8'h4B}; // ROL
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 8'h00, 1'b0, 1'b0, 8'hA5}; // ROR
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 8'h00, 1'b1, 1'b0, 8'h4A}; // SHL si_r=0
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 8'h00, 1'b0, 1'b1, 8'h25}; // SHR si_l=0
    vecs[10] = '{1'b1, 1'b0, 3'b110, 8'hFF, 1'b1, 1'b1, 8'h00}; // clear
    vecs[11] = '{1'b1, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0, 8'h3C}; // start ignored, load
    vecs[12] = '{1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h00}; // start ignored, clear
    vecs[13] = '{1'b1, 1'b0, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81}; // load 81

    // Reset with random inputs.
    reset = 1'b1;
    en    = 1'($urandom);
    mode  = 3'($urandom);
    d_in  = 8'($urandom);
    si_l  = 1'($urandom);
    si_r  = 1'($urandom);
    start = 1'($urandom);
    cnt   = 4'($urandom);
    tick();
    en    = 1'($urandom);
    mode  = 3'($urandom);
    start = 1'($urandom);
    tick();
    check_out("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    cnt   = '0;

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      en    = vecs[i].en;
      start = vecs[i].start;
      mode  = vecs[i].mode;
      d_in  = vecs[i].d_in;
      si_l  = vecs[i].si_l;
      si_r  = vecs[i].si_r;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].exp_q, 1'b0, 1'b0);
      check($sformatf("vec%0d.so_l", i), 32'(so_l), 32'(vecs[i].exp_q[WIDTH-1]));
      check($sformatf("vec%0d.so_r", i), 32'(so_r), 32'(vecs[i].exp_q[0]));
    end
    start = 1'b0;

    // Rotate-right burst of 3 from q=81.
    en = 1'b1; start = 1'b1; mode = 3'b101; cnt = 4'd3;
    tick();
    check_out("ror.arm", 8'h81, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000; cnt = 4'd0;
    tick();
    check_out("ror.s1", 8'hC0, 1'b1, 1'b0);
    tick();
    check_out("ror.s2", 8'h60, 1'b1, 1'b0);
    tick();
    check_out("ror.done", 8'h30, 1'b0, 1'b1);
    tick();
    check_out("ror.idle", 8'h30, 1'b0, 1'b0);

    // Paused SHR burst of 4 from q=00 with si_l=1; mode/d_in changes ignored.
    en = 1'b1; mode = 3'b110;
    tick();
    check_out("pause.clr", 8'h00, 1'b0, 1'b0);
    busy_cycles = 0;
    start = 1'b1; mode = 3'b011; cnt = 4'd4; si_l = 1'b1;
    tick();
    busy_cycles += int'(busy);
    check_out("pause.arm", 8'h00, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b001; d_in = 8'hFF;
    tick();
    busy_cycles += int'(busy);
    check_out("pause.s1", 8'h80, 1'b1, 1'b0);
    mode = 3'b110;
    tick();
    busy_cycles += int'(busy);
    check_out("pause.s2", 8'hC0, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    busy_cycles += int'(busy);
    check_out("pause.p1", 8'hC0, 1'b1, 1'b0);
    tick();
    busy_cycles += int'(busy);
    check_out("pause.p2", 8'hC0, 1'b1, 1'b0);
    en = 1'b1;
    tick();
    busy_cycles += int'(busy);
    check_out("pause.s3", 8'hE0, 1'b1, 1'b0);
    tick();
    busy_cycles += int'(busy);
    check_out("pause.done", 8'hF0, 1'b0, 1'b1);
    check("pause.busy_cycles", 32'(busy_cycles), 32'd6);
    mode = 3'b000;
    tick();

    // Reset during a ROL burst of 10 after 3 steps.
    mode = 3'b001; d_in = 8'h01;
    tick();
    check_out("rst.load", 8'h01, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b100; cnt = 4'd10;
    tick();
    check_out("rst.arm", 8'h01, 1'b1, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick();
    tick();
    tick();
    check_out("rst.s3", 8'h08, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check_out("rst.after", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    done_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      done_pulses += int'(done);
    end
    check("rst.no_done", 32'(done_pulses), 32'd0);
    check_out("rst.idle", 8'h00, 1'b0, 1'b0);

    // Zero-count burst, then start held through DONE is ignored.
    mode = 3'b001; d_in = 8'h3C;
    tick();
    check_out("zero.load", 8'h3C, 1'b0, 1'b0);
    start = 1'b1; mode = 3'b010; cnt = 4'd0; si_r = 1'b1;
    tick();
    check_out("zero.done", 8'h3C, 1'b0, 1'b1);
    cnt = 4'd2;
    tick();
    check_out("zero.idle", 8'h3C, 1'b0, 1'b0);
    start = 1'b0; mode = 3'b000;
    tick();
    check_out("zero.hold", 8'h3C, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
